rr_mult_sched: RTL and testbench

- Sequencer for the MSDF radix-R online multiplier.
- Accepts operand digit pairs (x_k, y_k) MSD-first over a valid/ready handshake.
- Maintains the appended operand vectors X[j] and Y[j].
- Time-shares one rR_mult_pp partial-product generator between the two online terms, x_k·Y[k] and y_k·X[k-1], across two phases.
- Controls the residual datapath and returns result digits over a valid/ready handshake once the online delay has elapsed.

---
 rtl/rr_pkg.sv | 41 ++++
 rtl/rr_digit_append.sv | 57 +++++
 rtl/rr_mult_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_rr_mult_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// ----------------------------------------------------------------------------
// rr_pkg
// Shared definitions for the MSDF radix-R online multiplier sequencer:
//   - digit width derived from the radix
//   - the illegal digit code (MSB set, all other bits clear)
//   - scheduler state encoding
//   - operand slot index helper (MSD lives in the top slot)
// ----------------------------------------------------------------------------
package rr_pkg;

  // Widest digit the helpers below are able to describe.
  localparam int unsigned MAX_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_PH0     = 3'd2,
    ST_PH1     = 3'd3,
    ST_OUT     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Signed digit in [-(R-1), R-1] needs log2(R) magnitude bits plus a sign.
  function automatic int digit_width(input int radix);
    return $clog2(radix) + 1;
  endfunction

  // The most negative two's complement code lies outside the digit set.
  // Returned zero-extended to MAX_DW bits.
  function automatic logic [MAX_DW-1:0] illegal_code(input int dw);
    logic [MAX_DW-1:0] one_v;
    one_v = {{(MAX_DW-1){1'b0}}, 1'b1};
    return one_v << (dw - 1);
  endfunction

  // Digit k of an MSD-first operand occupies slot n-1-k.
  function automatic int slot_idx(input int n, input int k);
    return n - 1 - k;
  endfunction

endpackage

// File: rtl/rr_digit_append.sv
// ----------------------------------------------------------------------------
// rr_digit_append
// Appended-operand register file holding X[j] and Y[j] as packed vectors of
// N digits. One slot index is shared by both write enables; clr_i wipes both
// vectors at the start of an operation.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           synchronous clear of both vectors
//   we_x_i, we_y_i  write x_digit_i / y_digit_i into slot slot_i
//   slot_i          target slot (N-1 is the most significant)
//   x_vec_o, y_vec_o current packed X and Y vectors
// ----------------------------------------------------------------------------
module rr_digit_append #(
  parameter  int D      = 3,
  parameter  int N      = 8,
  localparam int SLOT_W = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              we_x_i,
  input  logic              we_y_i,
  input  logic [SLOT_W-1:0] slot_i,
  input  logic [D-1:0]      x_digit_i,
  input  logic [D-1:0]      y_digit_i,
  output logic [D*N-1:0]    x_vec_o,
  output logic [D*N-1:0]    y_vec_o
);

  logic [D*N-1:0] x_q;
  logic [D*N-1:0] y_q;

  // Slot-addressed writes into the X and Y operand vectors.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (we_x_i && (slot_i == SLOT_W'(i))) begin
          x_q[i*D +: D] <= x_digit_i;
        end
        if (we_y_i && (slot_i == SLOT_W'(i))) begin
          y_q[i*D +: D] <= y_digit_i;
        end
      end
    end
  end

  assign x_vec_o = x_q;
  assign y_vec_o = y_q;

endmodule

// File: rtl/rr_mult_sched.sv
// ----------------------------------------------------------------------------
// rr_mult_sched
// Sequencer for the MSDF radix-R online multiplier. Accepts operand digit
// pairs MSD-first, keeps the appended operands X/Y, time-shares one partial
// product generator between x_k*Y[k] (phase 0) and y_k*X[k-1] (phase 1), and
// returns result digits after the online delay.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, busy, done, err        operation control / status
//   in_valid, in_ready, in_x/y    operand digit handshake
//   dp_a, dp_b                    vector / digit operands to rR_mult_pp
//   dp_clr, dp_acc, dp_phase,
//   dp_shift, dp_z                residual datapath control and selected digit
//   z_digit, z_valid, z_ready     result digit handshake
// ----------------------------------------------------------------------------
module rr_mult_sched
  import rr_pkg::*;
#(
  parameter  int RADIX = 4,
  parameter  int N     = 8,
  parameter  int DELTA = 2,
  localparam int D     = digit_width(RADIX)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D-1:0]   in_x,
  input  logic [D-1:0]   in_y,
  output logic [D*N-1:0] dp_a,
  output logic [D-1:0]   dp_b,
  output logic           dp_clr,
  output logic           dp_acc,
  output logic           dp_phase,
  output logic           dp_shift,
  input  logic [D-1:0]   dp_z,
  output logic [D-1:0]   z_digit,
  output logic           z_valid,
  input  logic           z_ready,
  output logic           done,
  output logic           err
);

  localparam int K_W    = $clog2(N + DELTA + 1);
  localparam int SLOT_W = $clog2(N);
  localparam logic [MAX_DW-1:0] ILLEGAL_CODE = illegal_code(D);

  state_e         state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [D-1:0]   xk_q, xk_d;
  logic [D-1:0]   yk_q, yk_d;
  logic [D-1:0]   z_q, z_d;
  logic           err_q, err_d;

  logic [K_W-1:0]    k_inc_s;
  logic              k_lt_n_s;
  logic              next_has_input_s;
  logic              k_last_s;
  logic              x_bad_s, y_bad_s;
  logic [D-1:0]      x_clean_s, y_clean_s;
  logic [SLOT_W-1:0] slot_s;
  logic              app_clr_s, we_x_s, we_y_s;
  logic [D*N-1:0]    x_vec_s, y_vec_s;

  assign k_inc_s          = k_q + K_W'(1);
  assign k_lt_n_s         = (k_q < K_W'(N));
  assign next_has_input_s = (k_inc_s < K_W'(N));
  assign k_last_s         = (k_q == K_W'(N + DELTA - 1));
  // Slot is only consumed while k < N, so truncation in the tail is harmless.
  assign slot_s           = SLOT_W'(slot_idx(N, int'(k_q)));

  // Illegal codes are replaced with zero so the pp generator never sees them.
  assign x_bad_s   = (MAX_DW'(in_x) == ILLEGAL_CODE);
  assign y_bad_s   = (MAX_DW'(in_y) == ILLEGAL_CODE);
  assign x_clean_s = x_bad_s ? '0 : in_x;
  assign y_clean_s = y_bad_s ? '0 : in_y;

  rr_digit_append #(
    .D (D),
    .N (N)
  ) u_append (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (app_clr_s),
    .we_x_i    (we_x_s),
    .we_y_i    (we_y_s),
    .slot_i    (slot_s),
    .x_digit_i (xk_q),
    .y_digit_i (y_clean_s),
    .x_vec_o   (x_vec_s),
    .y_vec_o   (y_vec_s)
  );

  // State and iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      xk_q    <= '0;
      yk_q    <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      xk_q    <= xk_d;
      yk_q    <= yk_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  // Next-state, register updates and datapath strobes.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    xk_d      = xk_q;
    yk_d      = yk_q;
    z_d       = z_q;
    err_d     = err_q;
    app_clr_s = 1'b0;
    we_x_s    = 1'b0;
    we_y_s    = 1'b0;
    in_ready  = 1'b0;
    dp_a      = '0;
    dp_b      = '0;
    dp_clr    = 1'b0;
    dp_acc    = 1'b0;
    dp_phase  = 1'b0;
    dp_shift  = 1'b0;
    z_valid   = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && rst_n) begin
          state_d   = ST_WAIT_IN;
          dp_clr    = 1'b1;
          app_clr_s = 1'b1;
          k_d       = '0;
          xk_d      = '0;
          yk_d      = '0;
          err_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          xk_d    = x_clean_s;
          yk_d    = y_clean_s;
          we_y_s  = 1'b1;
          err_d   = err_q | x_bad_s | y_bad_s;
          state_d = ST_PH0;
        end else begin
          state_d = ST_WAIT_IN;
        end
      end

      // Y already holds y_k, so this is x_k * Y[k].
      ST_PH0: begin
        dp_a    = y_vec_s;
        dp_b    = xk_q;
        dp_acc  = 1'b1;
        state_d = ST_PH1;
      end

      // X does not hold x_k yet, so this is y_k * X[k-1].
      ST_PH1: begin
        dp_a     = x_vec_s;
        dp_b     = yk_q;
        dp_acc   = 1'b1;
        dp_phase = 1'b1;
        dp_shift = 1'b1;
        we_x_s   = k_lt_n_s;
        if (k_q >= K_W'(DELTA)) begin
          z_d     = dp_z;
          state_d = ST_OUT;
        end else begin
          k_d = k_inc_s;
          if (next_has_input_s) begin
            state_d = ST_WAIT_IN;
          end else begin
            state_d = ST_PH0;
            xk_d    = '0;
            yk_d    = '0;
          end
        end
      end

      ST_OUT: begin
        z_valid = 1'b1;
        if (z_ready) begin
          k_d = k_inc_s;
          if (k_last_s) begin
            state_d = ST_DONE;
          end else if (next_has_input_s) begin
            state_d = ST_WAIT_IN;
          end else begin
            // Tail iteration: no handshake, operand digits are zero.
            state_d = ST_PH0;
            xk_d    = '0;
            yk_d    = '0;
          end
        end else begin
          state_d = ST_OUT;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign z_digit = z_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rr_mult_sched.sv
module tb_rr_mult_sched;

  localparam int RADIX = 4;
  localparam int N     = 4;
  localparam int DELTA = 2;
  localparam int D     = 3;
  localparam int NIT   = N + DELTA;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           busy;
  logic           in_valid;
  logic           in_ready;
  logic [D-1:0]   in_x;
  logic [D-1:0]   in_y;
  logic [D*N-1:0] dp_a;
  logic [D-1:0]   dp_b;
  logic           dp_clr;
  logic           dp_acc;
  logic           dp_phase;
  logic           dp_shift;
  logic [D-1:0]   dp_z;
  logic [D-1:0]   z_digit;
  logic           z_valid;
  logic           z_ready;
  logic           done;
  logic           err;

  rr_mult_sched #(
    .RADIX (RADIX),
    .N     (N),
    .DELTA (DELTA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .dp_clr   (dp_clr),
    .dp_acc   (dp_acc),
    .dp_phase (dp_phase),
    .dp_shift (dp_shift),
    .dp_z     (dp_z),
    .z_digit  (z_digit),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [D-1:0] xs    [N];
  logic [D-1:0] ys    [N];
  logic [D-1:0] zbase [6];
  logic [D-1:0] sb    [$];
  logic [D-1:0] exp_z0;
  logic [D-1:0] exp_v;
  int  iter;
  int  acc_idx;
  int  n_rx;
  int  op_id;
  int  bad_k;
  bit  acc_pend;
  int  done_rel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic bit in4(input int v, input int a, input int b, input int c, input int d);
    return (v == a) || (v == b) || (v == c) || (v == d);
  endfunction

  task automatic drive_digits();
    if (acc_idx < N) begin
      in_x = (acc_idx == bad_k) ? 3'b100 : xs[acc_idx];
      in_y = ys[acc_idx];
    end else begin
      in_x = 3'b000;
      in_y = 3'b000;
    end
  endtask

  // Negedge observation: datapath model drives dp_z, scoreboard checks digits.
  task automatic sample();
    @(negedge clk);
    if (dp_shift) begin
      dp_z = zbase[(iter + op_id) % 6];
      if (iter >= DELTA) sb.push_back(dp_z);
      iter++;
    end else begin
      dp_z = 3'b000;
    end
    if (z_valid && z_ready) begin
      n_rx++;
      chk("z_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        chk("z_digit", 32'(z_digit), 32'(exp_v));
      end
    end
    acc_pend = in_valid && in_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (acc_pend) acc_idx++;
    drive_digits();
  endtask

  task automatic run_op(input int stall_len, input int gap_len, input int bad,
                        input int abort_at, input bit timing, output int drel);
    sb.delete();
    iter    = 0;
    acc_idx = 0;
    n_rx    = 0;
    op_id++;
    bad_k   = bad;
    exp_z0  = zbase[(DELTA + op_id) % 6];
    drive_digits();
    drel = -1;
    for (int rel = 0; rel < 80; rel++) begin
      start    = (rel == 0);
      in_valid = !(rel >= 4 && rel < 4 + gap_len);
      z_ready  = !(rel >= 10 && rel < 10 + stall_len);
      sample();
      if (rel == 1) chk("err_clear_on_start", 32'(err), 32'd0);
      if (timing) begin
        chk("in_ready_t", 32'(in_ready), 32'(in4(rel, 1, 4, 7, 11)));
        chk("z_valid_t",  32'(z_valid),  32'(in4(rel, 10, 14, 17, 20)));
        chk("done_t",     32'(done),     32'(rel == 21));
        chk("busy_t",     32'(busy),     32'(rel >= 1 && rel <= 21));
        if (rel <= 1) chk("dp_clr_t", 32'(dp_clr), 32'(rel == 0));
        if (rel == 2) begin
          chk("k0_ph0_a", 32'(dp_a), 32'h400);
          chk("k0_ph0_b", 32'(dp_b), 32'b001);
          chk("k0_ph0_acc", 32'({dp_acc, dp_phase, dp_shift}), 32'b100);
        end
        if (rel == 3) begin
          chk("k0_ph1_a", 32'(dp_a), 32'h000);
          chk("k0_ph1_b", 32'(dp_b), 32'b010);
          chk("k0_ph1_acc", 32'({dp_acc, dp_phase, dp_shift}), 32'b111);
        end
        if (rel == 5) begin
          chk("k1_ph0_a", 32'(dp_a), 32'h4C0);
          chk("k1_ph0_b", 32'(dp_b), 32'b111);
        end
        if (rel == 6) begin
          chk("k1_ph1_a", 32'(dp_a), 32'h200);
          chk("k1_ph1_b", 32'(dp_b), 32'b011);
        end
      end
      if (stall_len > 0 && rel >= 10 && rel <= 10 + stall_len && rel != abort_at + 1) begin
        chk("stall_z_valid",  32'(z_valid),  32'd1);
        chk("stall_z_digit",  32'(z_digit),  32'(exp_z0));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_dp_acc",   32'(dp_acc),   32'd0);
      end
      if (gap_len > 0 && rel >= 4 && rel < 4 + gap_len) begin
        chk("gap_in_ready", 32'(in_ready), 32'd1);
        chk("gap_dp_acc",   32'(dp_acc),   32'd0);
      end
      if (bad >= 0 && rel == 8) begin
        chk("bad_ph0_dp_b", 32'(dp_b), 32'd0);
        chk("bad_ph0_acc",  32'(dp_acc), 32'd1);
      end
      if (bad >= 0 && rel >= 8) chk("bad_err_sticky", 32'(err), 32'd1);
      if (done) begin
        drel = rel;
        chk("digits_out", 32'(n_rx), 32'(N));
        chk("sb_empty",   32'(sb.size()), 32'd0);
        chk("err_at_done", 32'(err), 32'(bad >= 0));
      end
      if (rel == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_z_valid", 32'(z_valid), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_dp_a",    32'(dp_a),    32'd0);
        chk("rst_z_digit", 32'(z_digit), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      advance();
      if (drel >= 0) break;
    end
    chk("done_seen", 32'(drel >= 0), 32'd1);
  endtask

  initial begin
    xs[0] = 3'b001; xs[1] = 3'b111; xs[2] = 3'b010; xs[3] = 3'b000;
    ys[0] = 3'b010; ys[1] = 3'b011; ys[2] = 3'b110; ys[3] = 3'b001;
    zbase[0] = 3'b011; zbase[1] = 3'b110; zbase[2] = 3'b001;
    zbase[3] = 3'b111; zbase[4] = 3'b010; zbase[5] = 3'b101;
    op_id    = 0;
    bad_k    = -1;
    acc_idx  = 0;
    iter     = 0;
    n_rx     = 0;
    acc_pend = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_x     = 3'b000;
    in_y     = 3'b000;
    z_ready  = 1'b0;
    dp_z     = 3'b000;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",     32'(busy),     32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_dp_a",     32'(dp_a),     32'd0);
    chk("reset_dp_b",     32'(dp_b),     32'd0);
    chk("reset_strobes",  32'({dp_clr, dp_acc, dp_phase, dp_shift}), 32'd0);
    chk("reset_z",        32'({z_valid, z_digit}), 32'd0);
    chk("reset_done_err", 32'({done, err}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal timing and operand scheduling.
    run_op(0, 0, -1, -1, 1'b1, done_rel);
    chk("done_rel_nominal", 32'(done_rel), 32'd21);

    // Five cycles of result backpressure at the first output digit.
    run_op(5, 0, -1, -1, 1'b0, done_rel);
    chk("done_rel_stall", 32'(done_rel), 32'd26);

    // Three-cycle input gap at k=1.
    run_op(0, 3, -1, -1, 1'b0, done_rel);
    chk("done_rel_gap", 32'(done_rel), 32'd24);

    // Illegal x digit at k=2.
    run_op(0, 0, 2, -1, 1'b0, done_rel);
    chk("done_rel_bad", 32'(done_rel), 32'd21);

    // Reset while an output digit is pending.
    run_op(3, 0, -1, 10, 1'b0, done_rel);
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Clean operation after the mid-operation reset.
    run_op(0, 0, -1, -1, 1'b0, done_rel);
    chk("done_rel_after_rst", 32'(done_rel), 32'd21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
